hazard_controller: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core.
- Decides each cycle whether PC and pipeline registers advance, stall, flush or freeze, from decoded control fields carried in the ID, EX and MEM stages.
- Owns a data-memory wait FSM with timeout, plus saturating performance counters.
- Sits beside the decode control unit; drives PC/IF-ID/ID-EX/EX-MEM write and flush enables.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/sat_counter.sv | 33 +++
 rtl/hazard_controller.sv | 170 +++++++++++++++++
 tb/tb_hazard_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
// Contents: FSM state encoding, hazard event priority enum, opcode/funct constants
//           and small decode helpers.
package mips_pkg;

   // Data-memory wait FSM encoding
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERROR    = 2'd2
   } state_e;

   // Pipeline events; lower enum value = higher priority
   typedef enum logic [2:0] {
      EV_NONE     = 3'd0,
      EV_FREEZE   = 3'd1,
      EV_BRANCH   = 3'd2,
      EV_LOAD_USE = 3'd3,
      EV_JR_HAZ   = 3'd4,
      EV_JUMP     = 3'd5
   } event_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] FUNCT_JR = 6'h08;

   // Decode helpers for the control unit feeding id_jump / id_jr
   function automatic logic is_jump_op(input logic [5:0] op);
      return (op == OP_J) || (op == OP_JAL);
   endfunction

   function automatic logic is_jr_op(input logic [5:0] op, input logic [5:0] funct);
      return (op == OP_RTYPE) && (funct == FUNCT_JR);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Ports: clk_i, clear_i (synchronous clear, dominates), inc_i, count_o.
// Latency: count_o reflects an increment one cycle after inc_i.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         clear_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: PC / stage-register write and flush enables from
// ID/EX/MEM control fields, data-memory wait FSM with timeout, saturating counters.
// Ports: clk_i, reset_ni (sync, active-low), ID/EX/MEM decode fields, mem_ready_i in;
//        write/flush enables, pc_src_branch_o, mem_timeout_o, three counters out.
module hazard_controller
   import mips_pkg::*;
#(
   parameter int REG_W   = 5,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic             id_uses_rt_i,
   input  logic             id_jump_i,
   input  logic             id_jr_i,
   input  logic             ex_mem_read_i,
   input  logic             ex_reg_write_i,
   input  logic [REG_W-1:0] ex_wreg_i,
   input  logic             ex_branch_taken_i,
   input  logic             mem_mem_read_i,
   input  logic             mem_mem_write_i,
   input  logic [REG_W-1:0] mem_wreg_i,
   input  logic             mem_ready_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             idex_write_o,
   output logic             exmem_write_o,
   output logic             ifid_flush_o,
   output logic             idex_flush_o,
   output logic             pc_src_branch_o,
   output logic             mem_timeout_o,
   output logic [CNT_W-1:0] stall_count_o,
   output logic [CNT_W-1:0] flush_count_o,
   output logic [CNT_W-1:0] freeze_count_o
);

   // Wait counter only ever reaches TIMEOUT-1
   localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_e            state_q;
   logic [WAIT_W-1:0] wait_cnt_q;
   logic              mem_timeout_q;

   logic   mem_acc;
   logic   freeze_c, load_use_c, jr_haz_c, jump_c;
   event_e ev;

   assign mem_acc = mem_mem_read_i | mem_mem_write_i;

   // A zero-wait access (ready in its first cycle) never freezes
   assign freeze_c = (state_q == ST_MEM_WAIT) || (state_q == ST_ERROR) ||
                     ((state_q == ST_RUN) && mem_acc && !mem_ready_i);

   assign load_use_c = ex_mem_read_i && (ex_wreg_i != '0) &&
                       ((ex_wreg_i == id_rs_i) || (id_uses_rt_i && (ex_wreg_i == id_rt_i)));

   // JR reads rs in ID, so even an ALU result still in EX, or a load in MEM, is too late
   assign jr_haz_c = id_jr_i && (id_rs_i != '0) &&
                     ((ex_reg_write_i && (ex_wreg_i == id_rs_i)) ||
                      (mem_mem_read_i && (mem_wreg_i == id_rs_i)));

   assign jump_c = id_jump_i | id_jr_i;

   always_comb begin
      ev = EV_NONE;
      if (freeze_c)        ev = EV_FREEZE;
      else if (ex_branch_taken_i) ev = EV_BRANCH;
      else if (load_use_c) ev = EV_LOAD_USE;
      else if (jr_haz_c)   ev = EV_JR_HAZ;
      else if (jump_c)     ev = EV_JUMP;
   end

   always_comb begin
      pc_write_o      = 1'b1;
      ifid_write_o    = 1'b1;
      idex_write_o    = 1'b1;
      exmem_write_o   = 1'b1;
      ifid_flush_o    = 1'b0;
      idex_flush_o    = 1'b0;
      pc_src_branch_o = 1'b0;
      if (!reset_ni) begin
         // Hold PC while the stages fill with bubbles
         pc_write_o   = 1'b0;
         ifid_flush_o = 1'b1;
         idex_flush_o = 1'b1;
      end else begin
         unique case (ev)
            EV_FREEZE: begin
               pc_write_o    = 1'b0;
               ifid_write_o  = 1'b0;
               idex_write_o  = 1'b0;
               exmem_write_o = 1'b0;
            end
            EV_BRANCH: begin
               pc_src_branch_o = 1'b1;
               ifid_flush_o    = 1'b1;
               idex_flush_o    = 1'b1;
            end
            EV_LOAD_USE, EV_JR_HAZ: begin
               pc_write_o   = 1'b0;
               ifid_write_o = 1'b0;
               idex_flush_o = 1'b1;
            end
            EV_JUMP: ifid_flush_o = 1'b1;
            default: ;
         endcase
      end
   end

   // Memory wait FSM; ERROR is left only through reset
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q       <= ST_RUN;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (mem_acc && !mem_ready_i) begin
                  state_q    <= ST_MEM_WAIT;
                  wait_cnt_q <= WAIT_W'(1);
               end
            end
            ST_MEM_WAIT: begin
               if (mem_ready_i) begin
                  state_q    <= ST_RUN;
                  wait_cnt_q <= '0;
               end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                  state_q       <= ST_ERROR;
                  mem_timeout_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
               end
            end
            ST_ERROR: state_q <= ST_ERROR;
            default: begin
               state_q    <= ST_RUN;
               wait_cnt_q <= '0;
            end
         endcase
      end
   end

   assign mem_timeout_o = mem_timeout_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i   (clk_i),
      .clear_i (!reset_ni),
      .inc_i   ((ev == EV_LOAD_USE) || (ev == EV_JR_HAZ)),
      .count_o (stall_count_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i   (clk_i),
      .clear_i (!reset_ni),
      .inc_i   ((ev == EV_BRANCH) || (ev == EV_JUMP)),
      .count_o (flush_count_o)
   );

   sat_counter #(.W(CNT_W)) u_freeze_cnt (
      .clk_i   (clk_i),
      .clear_i (!reset_ni),
      .inc_i   (ev == EV_FREEZE),
      .count_o (freeze_count_o)
   );

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller with TIMEOUT=4 and CNT_W=3 (counters saturate at 7).
// Table of single-cycle hazard vectors plus hand sequences for reset, freeze,
// timeout and JR stall-then-flush.
module tb_hazard_controller;

   localparam int CMAX = 7;

   // Control pattern: {pc_w, ifid_w, idex_w, exmem_w, ifid_fl, idex_fl, pc_src}
   localparam logic [6:0] C_DEF    = 7'b1111_000;
   localparam logic [6:0] C_STALL  = 7'b0011_010;
   localparam logic [6:0] C_BRANCH = 7'b1111_111;
   localparam logic [6:0] C_JUMP   = 7'b1111_100;
   localparam logic [6:0] C_FREEZE = 7'b0000_000;
   localparam logic [6:0] C_RESET  = 7'b0111_110;

   // Counter effect of a cycle
   localparam int K_NONE = 0, K_STALL = 1, K_FLUSH = 2, K_FREEZE = 3, K_RESET = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [4:0] id_rs, id_rt, ex_wreg, mem_wreg;
   logic       id_uses_rt, id_jump, id_jr, ex_mem_read, ex_reg_write, ex_branch_taken;
   logic       mem_mem_read, mem_mem_write, mem_ready;
   logic       pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush;
   logic       pc_src_branch, mem_timeout;
   logic [2:0] stall_count, flush_count, freeze_count;

   int n_cmp  = 0;
   int n_fail = 0;
   int m_stall = 0, m_flush = 0, m_freeze = 0;

   always #5 clk = ~clk;

   hazard_controller #(.REG_W(5), .TIMEOUT(4), .CNT_W(3)) dut (
      .clk_i             (clk),
      .reset_ni          (reset_n),
      .id_rs_i           (id_rs),
      .id_rt_i           (id_rt),
      .id_uses_rt_i      (id_uses_rt),
      .id_jump_i         (id_jump),
      .id_jr_i           (id_jr),
      .ex_mem_read_i     (ex_mem_read),
      .ex_reg_write_i    (ex_reg_write),
      .ex_wreg_i         (ex_wreg),
      .ex_branch_taken_i (ex_branch_taken),
      .mem_mem_read_i    (mem_mem_read),
      .mem_mem_write_i   (mem_mem_write),
      .mem_wreg_i        (mem_wreg),
      .mem_ready_i       (mem_ready),
      .pc_write_o        (pc_write),
      .ifid_write_o      (ifid_write),
      .idex_write_o      (idex_write),
      .exmem_write_o     (exmem_write),
      .ifid_flush_o      (ifid_flush),
      .idex_flush_o      (idex_flush),
      .pc_src_branch_o   (pc_src_branch),
      .mem_timeout_o     (mem_timeout),
      .stall_count_o     (stall_count),
      .flush_count_o     (flush_count),
      .freeze_count_o    (freeze_count)
   );

   typedef struct {
      string      name;
      logic [4:0] rs, rt;
      logic       uses_rt, jump, jr, ex_rd, ex_rw;
      logic [4:0] ex_wreg;
      logic       br, mem_rd;
      logic [4:0] mem_wreg;
      logic [6:0] exp;
      int         kind;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v < CMAX) ? v + 1 : CMAX;
   endfunction

   task automatic clear_inputs();
      id_rs = 0; id_rt = 0; id_uses_rt = 0; id_jump = 0; id_jr = 0;
      ex_mem_read = 0; ex_reg_write = 0; ex_wreg = 0; ex_branch_taken = 0;
      mem_mem_read = 0; mem_mem_write = 0; mem_wreg = 0; mem_ready = 1;
   endtask

   // Inputs are already applied (1ns after an edge); check controls mid-cycle,
   // clock the edge, then check counters against the model.
   task automatic cycle(input string name, input logic [6:0] exp_ctl, input int kind);
      #3;
      chk({name, ".ctl"}, {25'd0, pc_write, ifid_write, idex_write, exmem_write,
                           ifid_flush, idex_flush, pc_src_branch}, {25'd0, exp_ctl});
      case (kind)
         K_STALL:  m_stall  = sat(m_stall);
         K_FLUSH:  m_flush  = sat(m_flush);
         K_FREEZE: m_freeze = sat(m_freeze);
         K_RESET:  begin m_stall = 0; m_flush = 0; m_freeze = 0; end
         default: ;
      endcase
      @(posedge clk);
      #1;
      chk({name, ".stall_cnt"},  32'(stall_count),  32'(m_stall));
      chk({name, ".flush_cnt"},  32'(flush_count),  32'(m_flush));
      chk({name, ".freeze_cnt"}, 32'(freeze_count), 32'(m_freeze));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //             name            rs  rt  ur jp jr erd erw ewr br mrd mwr  exp       kind
      vecs[0]  = '{"none",          8,  9,  1, 0, 0, 1,  0,  10, 0, 0,  0,  C_DEF,    K_NONE};
      vecs[1]  = '{"lu_rs",         8,  9,  1, 0, 0, 1,  1,  8,  0, 0,  0,  C_STALL,  K_STALL};
      vecs[2]  = '{"lu_rt",         9,  8,  1, 0, 0, 1,  1,  8,  0, 0,  0,  C_STALL,  K_STALL};
      vecs[3]  = '{"lu_rt_unused",  9,  8,  0, 0, 0, 1,  1,  8,  0, 0,  0,  C_DEF,    K_NONE};
      vecs[4]  = '{"lu_reg0",       0,  0,  1, 0, 0, 1,  1,  0,  0, 0,  0,  C_DEF,    K_NONE};
      vecs[5]  = '{"alu_dep",       8,  9,  1, 0, 0, 0,  1,  8,  0, 0,  0,  C_DEF,    K_NONE};
      vecs[6]  = '{"br_over_lu",    8,  9,  1, 0, 0, 1,  1,  8,  1, 0,  0,  C_BRANCH, K_FLUSH};
      vecs[7]  = '{"jump",          0,  0,  0, 1, 0, 0,  0,  0,  0, 0,  0,  C_JUMP,   K_FLUSH};
      vecs[8]  = '{"jr_nohaz",      31, 0,  0, 0, 1, 0,  0,  31, 0, 0,  0,  C_JUMP,   K_FLUSH};
      vecs[9]  = '{"jr_ex",         31, 0,  0, 0, 1, 0,  1,  31, 0, 0,  0,  C_STALL,  K_STALL};
      vecs[10] = '{"jr_mem_load",   31, 0,  0, 0, 1, 0,  0,  5,  0, 1,  31, C_STALL,  K_STALL};
      vecs[11] = '{"jr_reg0",       0,  0,  0, 0, 1, 0,  1,  0,  0, 1,  0,  C_JUMP,   K_FLUSH};
      vecs[12] = '{"lu_over_jump",  8,  0,  0, 1, 0, 1,  1,  8,  0, 0,  0,  C_STALL,  K_STALL};
      vecs[13] = '{"br_over_jump",  0,  0,  0, 1, 0, 0,  0,  0,  1, 0,  0,  C_BRANCH, K_FLUSH};
      vecs[14] = '{"jump_sat",      0,  0,  0, 1, 0, 0,  0,  0,  0, 0,  0,  C_JUMP,   K_FLUSH};
      vecs[15] = '{"lu_sat",        4,  0,  0, 0, 0, 1,  1,  4,  0, 0,  0,  C_STALL,  K_STALL};

      clear_inputs();
      reset_n = 1'b0;
      // Load-use hazard present during reset: bubbles only, no counting
      ex_mem_read = 1; ex_reg_write = 1; ex_wreg = 8; id_rs = 8;
      @(posedge clk); #1;
      cycle("rst_hold", C_RESET, K_RESET);
      chk("rst.mem_timeout", 32'(mem_timeout), 32'd0);
      reset_n = 1'b1;

      // LW $t0 in EX, ADD reading $t0 in ID
      cycle("seq_lw_use", C_STALL, K_STALL);
      chk("seq_lw_use.stall_is_1", 32'(stall_count), 32'd1);

      // Taken BEQ beats the load-use hazard
      ex_branch_taken = 1;
      cycle("seq_br_lu", C_BRANCH, K_FLUSH);
      chk("seq_br_lu.flush_is_1", 32'(flush_count), 32'd1);
      clear_inputs();

      for (int i = 0; i < 16; i++) begin
         id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rt = vecs[i].uses_rt;
         id_jump = vecs[i].jump; id_jr = vecs[i].jr;
         ex_mem_read = vecs[i].ex_rd; ex_reg_write = vecs[i].ex_rw; ex_wreg = vecs[i].ex_wreg;
         ex_branch_taken = vecs[i].br;
         mem_mem_read = vecs[i].mem_rd; mem_wreg = vecs[i].mem_wreg; mem_ready = 1;
         cycle(vecs[i].name, vecs[i].exp, vecs[i].kind);
      end
      clear_inputs();

      // JR $ra with EX writing $ra: stall, then the JR flushes IF/ID
      id_jr = 1; id_rs = 31; ex_reg_write = 1; ex_wreg = 31;
      cycle("jr_seq_stall", C_STALL, K_STALL);
      ex_reg_write = 0; ex_wreg = 0;
      cycle("jr_seq_flush", C_JUMP, K_FLUSH);
      clear_inputs();

      // MEM read, ready low for 3 cycles then high: 4 frozen cycles
      mem_mem_read = 1; mem_ready = 0;
      cycle("frz1", C_FREEZE, K_FREEZE);
      ex_branch_taken = 1;   // freeze outranks the branch
      cycle("frz2", C_FREEZE, K_FREEZE);
      ex_branch_taken = 0;
      cycle("frz3", C_FREEZE, K_FREEZE);
      mem_ready = 1;
      cycle("frz4_ready", C_FREEZE, K_FREEZE);
      chk("frz.count_is_4", 32'(freeze_count), 32'd4);
      clear_inputs();
      cycle("frz_after_run", C_DEF, K_NONE);

      // Zero-wait write: no freeze
      mem_mem_write = 1; mem_ready = 1;
      cycle("zero_wait_wr", C_DEF, K_NONE);

      // Timeout: ready held low
      mem_ready = 0;
      for (int i = 1; i <= 4; i++) begin
         cycle($sformatf("tmo_wait%0d", i), C_FREEZE, K_FREEZE);
         chk($sformatf("tmo_wait%0d.mem_timeout", i), 32'(mem_timeout), (i == 4) ? 32'd1 : 32'd0);
      end
      // ERROR holds the freeze regardless of inputs; freeze_count saturates
      clear_inputs();
      ex_branch_taken = 1;
      for (int i = 0; i < 5; i++) begin
         cycle($sformatf("err%0d", i), C_FREEZE, K_FREEZE);
      end
      chk("err.mem_timeout_sticky", 32'(mem_timeout), 32'd1);
      chk("err.freeze_sat", 32'(freeze_count), 32'd7);

      // Reset for one edge leaves ERROR
      reset_n = 1'b0;
      cycle("err_reset", C_RESET, K_RESET);
      chk("err_reset.mem_timeout", 32'(mem_timeout), 32'd0);
      reset_n = 1'b1;
      clear_inputs();
      cycle("post_reset_run", C_DEF, K_NONE);
      ex_branch_taken = 1;
      cycle("post_reset_branch", C_BRANCH, K_FLUSH);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
